// File: rtl/tv_capture_ctrl_if.sv
// Decoder-side pixel bus and FIFO write port for tv_capture_ctrl.
// slave = capture controller, master = decoder/FIFO side.
interface tv_capture_ctrl_if;
    logic        iTV_DVAL;
    logic [15:0] iTV_YCbCr;
    logic [9:0]  iTV_X;
    logic [9:0]  iTV_Y;
    logic        iFIFO_FULL;
    logic        oFIFO_WR;
    logic [15:0] oFIFO_DATA;
    logic        oSkip;

    modport slave (
        input  iTV_DVAL, iTV_YCbCr, iTV_X, iTV_Y, iFIFO_FULL,
        output oFIFO_WR, oFIFO_DATA, oSkip
    );

    modport master (
        output iTV_DVAL, iTV_YCbCr, iTV_X, iTV_Y, iFIFO_FULL,
        input  oFIFO_WR, oFIFO_DATA, oSkip
    );
endinterface

// File: rtl/tv_capture_ctrl.sv
// Field-synchronous capture sequencer between the ITU-656 decoder and the frame-store FIFO.
// Optional 2:1 horizontal decimation when TV_CAPTURE_DECIM_EN is defined.
module tv_capture_ctrl #(
    parameter int unsigned H_START = 0,
    parameter int unsigned H_END   = 720,
    parameter int unsigned V_START = 1,
    parameter int unsigned V_END   = 241,
    parameter int unsigned FIELDS  = 2
) (
    input  logic                iCLK_27,
    input  logic                iRST_N,
    tv_capture_ctrl_if.slave    tv,
    input  logic                iCapture,
    input  logic                iStop,
    input  logic                iMode,
    input  logic                iClear,
    output logic                oBusy,
    output logic                oFrame_Done,
    output logic                oOverflow,
    output logic [19:0]         oPix_Cnt
);

    localparam logic [9:0] HStart    = 10'(H_START);
    localparam logic [9:0] HSpan     = 10'(H_END - H_START);
    localparam logic [9:0] VStart    = 10'(V_START);
    localparam logic [9:0] VSpan     = 10'(V_END - V_START);
    localparam logic [1:0] LastField = 2'(FIELDS - 1);

    typedef enum logic [1:0] {StIdle, StArm, StCapture} state_e;

    state_e      state_q, state_d;
    logic [1:0]  fc_q, fc_d;
    logic [19:0] pix_q, pix_d;
    logic [9:0]  y_q;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic        wr_q, wr_d;
    logic [15:0] data_q, data_d;
    logic        skip_q, skip_d;
    logic        fb, x_in, y_in, hit;

    assign fb = (y_q != 10'd0) && (tv.iTV_Y == 10'd0);

    // Offset-and-span range checks: unsigned wrap makes below-start values large.
    assign x_in = (10'(tv.iTV_X - HStart) < HSpan);
    assign y_in = (10'(tv.iTV_Y - VStart) < VSpan);

`ifdef TV_CAPTURE_DECIM_EN
    assign hit = (state_q == StCapture) && tv.iTV_DVAL && x_in && y_in && !tv.iTV_X[0];
`else
    assign hit = (state_q == StCapture) && tv.iTV_DVAL && x_in && y_in;
`endif

    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        pix_d   = pix_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        wr_d    = 1'b0;
        data_d  = data_q;

        if (hit && !tv.iFIFO_FULL) begin
            wr_d   = 1'b1;
            data_d = tv.iTV_YCbCr;
            if (pix_q != '1) pix_d = pix_q + 20'd1;
        end

        if (iClear) ovf_d = 1'b0;
        if (hit && tv.iFIFO_FULL) ovf_d = 1'b1;

        if (iStop) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (iCapture) begin
                        state_d = StArm;
                        pix_d   = '0;
                        fc_d    = '0;
                    end
                end
                StArm: begin
                    if (fb) begin
                        state_d = StCapture;
                        fc_d    = '0;
                    end
                end
                StCapture: begin
                    if (fb) begin
                        if (fc_q == LastField) begin
                            done_d = 1'b1;
                            fc_d   = '0;
                            if (iMode) pix_d = '0;
                            else       state_d = StIdle;
                        end else begin
                            fc_d = fc_q + 2'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // ARM keeps strobes enabled so the first captured field starts cleanly.
        skip_d = !((state_d == StArm) || (state_d == StCapture));
    end

    always_ff @(posedge iCLK_27 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= StIdle;
            fc_q    <= '0;
            pix_q   <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            skip_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
            pix_q   <= pix_d;
            y_q     <= tv.iTV_Y;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            skip_q  <= skip_d;
        end
    end

    assign tv.oFIFO_WR   = wr_q;
    assign tv.oFIFO_DATA = data_q;
    assign tv.oSkip      = skip_q;
    assign oBusy         = (state_q != StIdle);
    assign oFrame_Done   = done_q;
    assign oOverflow     = ovf_q;
    assign oPix_Cnt      = pix_q;

endmodule
